lock_access_controller: RTL and testbench
=========================================

// Module: lock_access_controller
// PURPOSE
//  Downstream stage of the six-digit lock controller. Consumes its match result (res) and the
//  judge-select strobe, and decides the lock's action: timed unlock, failed-attempt counting,
//  and alarm/lockout after too many failures. Also gates password-set mode (set_en): only true
//  while unlocked. All outputs are registered.
// PARAMETERS
//  MAX_FAIL        3     consecutive wrong attempts that trigger lockout (>=1)
//  UNLOCK_CYCLES   50    clk cycles the lock stays open after a correct code (>=2)
//  LOCKOUT_CYCLES  1000  clk cycles of lockout after MAX_FAIL failures (>=2)
//  TW              derived = $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)); timer width
// PORTS
//  clk        in   1   system clock, rising edge
//  clr_n      in   1   reset; asynchronous, active-low
//  m          in   1   mode from controller: 0 = set password, 1 = enter password
//  judge_req  in   1   judge-select level (decoder y3); rising edge = one attempt
//  res        in   1   match result from comparator; sampled on the judge_req edge cycle
//  relock     in   1   user relock; level, sampled each cycle
//  alarm_ack  in   1   silences alarm; lockout timer keeps running
//  unlock     out  1   lock actuator open
//  set_en     out  1   password register write permitted (=1 only in S_UNLOCK)
//  alarm      out  1   alarm sounder
//  locked_out out  1   attempts refused (=1 in S_LOCKOUT)
//  fail_cnt   out  2   consecutive failures, 0..MAX_FAIL
//  timer      out  TW  remaining cycles in current timed state; 0 in S_IDLE
//  state      out  2   S_IDLE=0, S_UNLOCK=1, S_LOCKOUT=2 (3 unused -> S_IDLE)
// BEHAVIOUR
//  Reset (clr_n=0, async): state=S_IDLE; unlock, set_en, alarm, locked_out, fail_cnt,
//   timer, judge_d all 0. judge_req held high through reset release gives no attempt.
//  Attempt: att = judge_req & ~judge_d & m (judge_d = judge_req delayed 1 clk). Attempts with
//   m=0 are ignored. Outputs update on the clk edge after the att cycle (1-cycle latency).
//  S_IDLE:
//   - att & res  -> S_UNLOCK, timer=UNLOCK_CYCLES-1, fail_cnt=0, unlock=1, set_en=1.
//   - att & ~res -> fail_cnt+1. If new count == MAX_FAIL: S_LOCKOUT, timer=LOCKOUT_CYCLES-1,
//     alarm=1, locked_out=1. Otherwise stay in S_IDLE.
//   - relock in S_IDLE: no effect.
//  S_UNLOCK: timer decrements by 1 per cycle.
//   - Leave to S_IDLE (unlock=set_en=0, timer=0) on relock=1, or on the cycle timer==0.
//   - att & res: timer reloads UNLOCK_CYCLES-1.
//   - att & ~res: ignored; fail_cnt unchanged.
//   - relock has priority over a simultaneous att.
//   - m may toggle freely; set_en does not depend on m.
//  S_LOCKOUT:
//   - All attempts and relock ignored. Timer decrements each cycle.
//   - alarm_ack=1 clears alarm on the next edge; alarm stays 0 for the rest of this lockout.
//   - On timer==0 -> S_IDLE: fail_cnt=0, alarm=0, locked_out=0.
//  Timer: never underflows; it holds 0 outside timed states. fail_cnt saturates at MAX_FAIL.
//  Illegal state encoding recovers to S_IDLE with all outputs cleared on the next edge.
// STRUCTURE
//  lock_defs.vh (shared with the controller): `defines for S_IDLE/S_UNLOCK/S_LOCKOUT codes and
//   the state width.
//  Sub-module lock_timer: loadable down-counter (load, load_val, en, count, zero).
//   Instantiated once; time-shared between S_UNLOCK and S_LOCKOUT.
//  Top holds the edge detector, FSM, fail counter and output registers.
// TESTING (MAX_FAIL=3, UNLOCK_CYCLES=5, LOCKOUT_CYCLES=8)
//  1 Reset with judge_req=1, release, hold -> no attempt; state=0, all outputs 0.
//  2 m=1, judge_req pulse with res=1 -> next edge unlock=1, set_en=1, timer=4.
//    Counts 4..0; unlock=0 on the 6th edge after the attempt.
//  3 Three pulses with res=0 -> fail_cnt 1,2, then locked_out=1, alarm=1, timer=7.
//    4th pulse with res=1 during lockout -> ignored. After 8 cycles: state=0, fail_cnt=0.
//  4 Lockout, alarm_ack=1 at timer=5 -> alarm=0 next edge; locked_out stays 1 until timer==0.
//  5 Unlocked at timer=2: relock=1 and att&res in the same cycle -> S_IDLE (relock wins).
//    Separately, att&res at timer=1 -> timer reloads to 4.
//  6 Two fails, then correct code -> unlock, fail_cnt=0. Pulse with m=0 -> no count change.
//    Assert clr_n=0 mid-unlock -> outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/lock_access_controller_pkg.sv
// Shared state encoding and helpers for the lock access controller.
package lock_access_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_UNLOCK  = 2'd1,
    S_LOCKOUT = 2'd2
  } lock_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_access_controller_timer.sv
// Loadable down-counter shared between the unlock window and the lockout period.
module lock_access_controller_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over decrement; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_access_controller.sv
// Decides lock action from match results: timed unlock, failure counting, alarm and lockout.
module lock_access_controller
  import lock_access_controller_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TW             = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES))
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               m,
  input  logic               judge_req,
  input  logic               res,
  input  logic               relock,
  input  logic               alarm_ack,
  output logic               unlock,
  output logic               set_en,
  output logic               alarm,
  output logic               locked_out,
  output logic [1:0]         fail_cnt,
  output logic [TW-1:0]      timer,
  output logic [STATE_W-1:0] state
);

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_MAX     = 2'(MAX_FAIL);
  localparam logic [1:0]    FAIL_LAST    = 2'(MAX_FAIL - 1);

  lock_state_t   state_q, state_n;
  logic          armed_q, judge_d, att;
  logic [1:0]    fail_q, fail_n;
  logic          unlock_q, unlock_n;
  logic          alarm_q, alarm_n;
  logic          locked_q, locked_n;
  logic          timer_load, timer_en, timer_zero;
  logic [TW-1:0] load_val;

  // armed_q masks the first cycle after reset so a judge_req held through release is not an edge.
  assign att = judge_req & ~judge_d & m & armed_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      judge_d  <= 1'b0;
      fail_q   <= 2'd0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      armed_q  <= 1'b1;
      judge_d  <= judge_req;
      fail_q   <= fail_n;
      unlock_q <= unlock_n;
      alarm_q  <= alarm_n;
      locked_q <= locked_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    fail_n     = fail_q;
    unlock_n   = unlock_q;
    alarm_n    = alarm_q;
    locked_n   = locked_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    load_val   = '0;
    case (state_q)
      S_IDLE: begin
        if (att && res) begin
          state_n    = S_UNLOCK;
          fail_n     = 2'd0;
          unlock_n   = 1'b1;
          timer_load = 1'b1;
          load_val   = UNLOCK_LOAD;
        end else if (att && (fail_q == FAIL_LAST)) begin
          state_n    = S_LOCKOUT;
          fail_n     = FAIL_MAX;
          alarm_n    = 1'b1;
          locked_n   = 1'b1;
          timer_load = 1'b1;
          load_val   = LOCKOUT_LOAD;
        end else if (att && (fail_q != FAIL_MAX)) begin
          fail_n = 2'(fail_q + 2'd1);
        end
      end
      S_UNLOCK: begin
        // relock beats a simultaneous correct code; a correct code beats expiry.
        if (relock || (timer_zero && !(att && res))) begin
          state_n    = S_IDLE;
          unlock_n   = 1'b0;
          timer_load = 1'b1;
        end else if (att && res) begin
          timer_load = 1'b1;
          load_val   = UNLOCK_LOAD;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (alarm_ack) alarm_n = 1'b0;
        if (timer_zero) begin
          state_n  = S_IDLE;
          fail_n   = 2'd0;
          alarm_n  = 1'b0;
          locked_n = 1'b0;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_n    = S_IDLE;
        fail_n     = 2'd0;
        unlock_n   = 1'b0;
        alarm_n    = 1'b0;
        locked_n   = 1'b0;
        timer_load = 1'b1;
      end
    endcase
  end

  lock_access_controller_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (timer_load),
    .load_val (load_val),
    .en       (timer_en),
    .count    (timer),
    .zero     (timer_zero)
  );

  assign unlock     = unlock_q;
  assign set_en     = unlock_q;
  assign alarm      = alarm_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed and randomized bench for lock_access_controller against a rule-level model.
module tb_lock_access_controller;

  localparam int MAX_FAIL = 3;
  localparam int UNL      = 5;
  localparam int LCK      = 8;

  logic       clk = 1'b0;
  logic       clr_n, m, judge_req, res, relock, alarm_ack;
  logic       unlock, set_en, alarm, locked_out;
  logic [1:0] fail_cnt;
  logic [2:0] timer;
  logic [1:0] state;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Model: 0 idle, 1 unlocked, 2 locked out
  int md_st, md_timer, md_fail;
  bit md_alarm, md_prev, md_armed;

  always #5 clk = ~clk;

  lock_access_controller #(
    .MAX_FAIL(MAX_FAIL), .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk(clk), .clr_n(clr_n), .m(m), .judge_req(judge_req), .res(res),
    .relock(relock), .alarm_ack(alarm_ack), .unlock(unlock), .set_en(set_en),
    .alarm(alarm), .locked_out(locked_out), .fail_cnt(fail_cnt), .timer(timer),
    .state(state)
  );

  task automatic model_reset();
    md_st = 0; md_timer = 0; md_fail = 0;
    md_alarm = 0; md_prev = 0; md_armed = 0;
  endtask

  task automatic model_step();
    bit att;
    att = m && judge_req && !md_prev && md_armed;
    if (md_st == 0) begin
      if (att && res) begin
        md_st = 1; md_timer = UNL - 1; md_fail = 0;
      end else if (att) begin
        md_fail = md_fail + 1;
        if (md_fail >= MAX_FAIL) begin
          md_fail = MAX_FAIL; md_st = 2; md_timer = LCK - 1; md_alarm = 1;
        end
      end
    end else if (md_st == 1) begin
      if (relock) begin
        md_st = 0; md_timer = 0;
      end else if (att && res) md_timer = UNL - 1;
      else if (md_timer == 0) md_st = 0;
      else md_timer = md_timer - 1;
    end else begin
      if (alarm_ack) md_alarm = 0;
      if (md_timer == 0) begin
        md_st = 0; md_fail = 0; md_alarm = 0;
      end else md_timer = md_timer - 1;
    end
    md_prev = judge_req;
    md_armed = 1;
  endtask

  task automatic check_model();
    logic [10:0] got, exp;
    got = {state, unlock, set_en, alarm, locked_out, fail_cnt, timer};
    exp = {2'(md_st), md_st == 1, md_st == 1, md_alarm, md_st == 2, 2'(md_fail), 3'(md_timer)};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL model[%s] got %b exp %b (st,unl,set,alm,lck,fail,tmr)", phase, got, exp);
    end
  endtask

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr_n) model_step();
    else model_reset();
    #1;
    check_model();
  endtask

  task automatic wait_timer(string tag, int val);
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (timer == 3'(val)) hit = 1;
      else tick();
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL %s timeout got timer %0d exp %0d", tag, timer, val);
    end
  endtask

  task automatic attempt(bit r);
    judge_req = 1; res = r;
    tick();
    judge_req = 0;
  endtask

  initial begin
    model_reset();
    clr_n = 0; m = 1; judge_req = 1; res = 1; relock = 0; alarm_ack = 0;

    // 1: judge_req held high through reset release
    phase = "reset";
    tick(); tick();
    #2 clr_n = 1;
    tick(); tick(); tick();
    expect_eq("reset_state", state, 0);
    expect_eq("reset_unlock", unlock, 0);
    expect_eq("reset_fail", fail_cnt, 0);
    judge_req = 0;
    tick();

    // 2: correct code and full unlock window
    phase = "unlock";
    attempt(1);
    expect_eq("unl_unlock", unlock, 1);
    expect_eq("unl_set_en", set_en, 1);
    expect_eq("unl_timer", timer, 4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_eq("unl_count", timer, 4 - i);
    end
    tick();
    expect_eq("unl_expire", unlock, 0);
    tick();

    // 3: three failures, ignored attempt, lockout expiry
    phase = "lockout";
    attempt(0); expect_eq("fail1", fail_cnt, 1); tick();
    attempt(0); expect_eq("fail2", fail_cnt, 2); tick();
    attempt(0);
    expect_eq("lck_locked", locked_out, 1);
    expect_eq("lck_alarm", alarm, 1);
    expect_eq("lck_timer", timer, 7);
    tick();
    attempt(1);
    expect_eq("lck_ignore", state, 2);
    for (int i = 0; i < 5; i++) tick();
    expect_eq("lck_last", locked_out, 1);
    tick();
    expect_eq("lck_exit_state", state, 0);
    expect_eq("lck_exit_fail", fail_cnt, 0);
    tick();

    // 4: alarm acknowledge during lockout
    phase = "ack";
    attempt(0); tick(); attempt(0); tick(); attempt(0);
    wait_timer("ack_wait5", 5);
    alarm_ack = 1;
    tick();
    alarm_ack = 0;
    expect_eq("ack_alarm", alarm, 0);
    expect_eq("ack_locked", locked_out, 1);
    wait_timer("ack_wait0", 0);
    expect_eq("ack_locked_end", locked_out, 1);
    tick();
    expect_eq("ack_exit", locked_out, 0);

    // 5: relock beats attempt; reload at timer 1
    phase = "relock";
    attempt(1); tick();
    wait_timer("rl_wait2", 2);
    relock = 1; judge_req = 1; res = 1;
    tick();
    relock = 0; judge_req = 0;
    expect_eq("rl_state", state, 0);
    expect_eq("rl_timer", timer, 0);
    tick();
    attempt(1); tick();
    wait_timer("rl_wait1", 1);
    attempt(1);
    expect_eq("reload_timer", timer, 4);
    tick();

    // 6: fails then success, m=0 ignored, async reset
    phase = "mixed";
    relock = 1; tick(); relock = 0;
    attempt(0); tick(); attempt(0); tick();
    attempt(1);
    expect_eq("mix_unlock", unlock, 1);
    expect_eq("mix_fail0", fail_cnt, 0);
    relock = 1; tick(); relock = 0;
    attempt(0); tick();
    m = 0; attempt(0); tick(); m = 1;
    expect_eq("mix_m0", fail_cnt, 1);
    attempt(1); tick();
    #3 clr_n = 0;
    #1 model_reset();
    check_model();
    expect_eq("async_unlock", unlock, 0);
    expect_eq("async_timer", timer, 0);
    tick();
    #2 clr_n = 1;

    // Random phase
    phase = "random";
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) judge_req = ~judge_req;
      m         = ($urandom_range(0, 7) != 0);
      res       = ($urandom_range(0, 2) == 0);
      relock    = ($urandom_range(0, 15) == 0);
      alarm_ack = ($urandom_range(0, 5) == 0);
      if (i == 400) begin
        #2 clr_n = 0;
        #1 model_reset();
        check_model();
        tick();
        #2 clr_n = 1;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
